gate2_tester: RTL
=================

# gate2_tester

Parametrised tester for 14-pin DIP parts holding identical 2-input logic gates (7400/7402/7408/7432/7486 family). It sweeps all four input combinations across every channel in parallel and waits a programmable settle time before sampling. It compares each gate output against the expected function and reports a single pass/fail plus optional per-channel diagnostics. It sits beside the other chip checkers under the top-level chip selector, with pin mapping to the DIP socket done outside this block.

## Interface
Parameters:
- CHANNELS, 4, number of gates tested in parallel (1..8)
- GATE_FN, 1, expected function: 0 NAND, 1 NOR, 2 AND, 3 OR, 4 XOR; 5..7 reserved, must not be used
- SETTLE_CYCLES, 2, cycles inputs are held before sampling (>=1)

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Run  in  1  start request, level-sampled in HALTED only
- DISP_RSLT  in  1  result acknowledged; releases DONE_S
- Sense  in  CHANNELS  gate outputs read back from the DUT
- DrvA  out  CHANNELS  A input to every gate
- DrvB  out  CHANNELS  B input to every gate
- Done  out  1  high while in DONE_S and in the final SAMPLE cycle
- RSLT  out  1  registered result: 1 = all gates passed
- Busy  out  1  high in SET, DRIVE, SAMPLE
- FailMask  out  CHANNELS  diagnostic only, see Configuration
- FailVec  out  2  diagnostic only
- FailValid  out  1  diagnostic only

One clock (Clk); reset is synchronous and active-high (Reset).

## Operation
- States: HALTED, SET, DRIVE, SAMPLE, DONE_S.
- HALTED: Run=1 -> SET, else stay.
- SET: vec<=0, settle count<=0, RSLT<=1, diagnostics cleared -> DRIVE.
- DRIVE: DrvA = {CHANNELS{vec[1]}}, DrvB = {CHANNELS{vec[0]}}. Count increments each cycle. After SETTLE_CYCLES cycles in DRIVE -> SAMPLE.
- SAMPLE: drives are held unchanged. Expected Y = GATE_FN(vec[1], vec[0]). Any channel with Sense != Y clears RSLT at the cycle end. If vec==3 -> DONE_S. Otherwise vec<=vec+1, count<=0 -> DRIVE.
- DONE_S: Done=1, drives 0. DISP_RSLT=1 -> HALTED, else stay.
- DrvA/DrvB are 0 in HALTED, SET and DONE_S.
- RSLT is sticky-low within a run. It holds its value through DONE_S and HALTED until the next SET.
- Run outside HALTED is ignored. DISP_RSLT outside DONE_S is ignored.
- Run and DISP_RSLT both high in DONE_S: go to HALTED. Run is then evaluated on the following cycle.
- Reset, including mid-sweep: next state HALTED, vec=0, count=0, RSLT=0, Done=0, Busy=0, drives 0, diagnostics 0.
- Sense is compared raw. External parts are static during the sweep, and SETTLE_CYCLES covers propagation and input sync.
- Counter width is $clog2(SETTLE_CYCLES+1). vec is 2 bits and never wraps, since SAMPLE at vec==3 exits.

## Timing
- Run high at edge k -> SET during cycle k+1. DRIVE for vec0 starts at cycle k+2.
- Each vector takes SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in DRIVE, 1 in SAMPLE.
- Final SAMPLE is at cycle k+1+4(SETTLE_CYCLES+1). DONE_S starts the next cycle. With the defaults, DONE_S begins at cycle k+14.
- RSLT updates at the edge ending each SAMPLE, so the final value is visible in the first DONE_S cycle.
- DONE_S -> HALTED takes one cycle after DISP_RSLT is sampled high.

## Configuration
- GATE2_TESTER_DIAG_EN defined:
  - FailMask is a sticky OR of per-channel mismatches over the run.
  - FailVec holds the vec of the first mismatching SAMPLE.
  - FailValid is set on that first mismatch.
  - All three clear in SET and on Reset.
- GATE2_TESTER_DIAG_EN undefined: FailMask, FailVec and FailValid are tied to 0, and no diagnostic registers are built. Pass/fail behaviour is identical either way.

## Test plan
- Default parameters, Sense model = ideal NOR of DrvA/DrvB; pulse Run -> DONE_S at cycle k+14, RSLT=1, FailValid=0. DISP_RSLT -> HALTED the next cycle.
- CHANNELS=4, NOR, channel 2 stuck at 1 -> RSLT=0. With DIAG_EN: FailMask=4'b0100, FailVec=2'b01 (first mismatch at A=0,B=1), FailValid=1.
- GATE_FN=4 (XOR), SETTLE_CYCLES=3, ideal XOR model -> RSLT=1. Each vector's drives are held for exactly 4 cycles, and DONE_S begins at cycle k+18.
- Reset asserted during DRIVE of vec=2 -> next cycle HALTED, drives 0, RSLT=0, Done=0. A subsequent Run performs a full clean sweep with RSLT=1.
- Run held high through the sweep, plus DISP_RSLT pulsed during DRIVE -> no restart, no early exit. In DONE_S, Run=1 and DISP_RSLT=1 together -> HALTED, then SET on the next cycle.
- Model the NOR output as lagging the drives by SETTLE_CYCLES-1 cycles -> RSLT=1. A lag of SETTLE_CYCLES+1 -> RSLT=0.

Source files
------------

// File: rtl/gate2_tester_if.sv
// Bus between the chip-selector controller and gate2_tester: run/ack handshake,
// DIP drive/sense lines, and the result/diagnostic outputs.
interface gate2_tester_if #(
  parameter int CHANNELS = 4
);
  logic                Run;
  logic                DISP_RSLT;
  logic [CHANNELS-1:0] Sense;
  logic [CHANNELS-1:0] DrvA;
  logic [CHANNELS-1:0] DrvB;
  logic                Done;
  logic                RSLT;
  logic                Busy;
  logic [CHANNELS-1:0] FailMask;
  logic [1:0]          FailVec;
  logic                FailValid;

  modport master (
    output Run, DISP_RSLT, Sense,
    input  DrvA, DrvB, Done, RSLT, Busy, FailMask, FailVec, FailValid
  );

  modport slave (
    input  Run, DISP_RSLT, Sense,
    output DrvA, DrvB, Done, RSLT, Busy, FailMask, FailVec, FailValid
  );
endinterface

// File: rtl/gate2_tester.sv
// Sweeps all four A/B combinations over CHANNELS identical 2-input gates and checks Sense.
// Optional diagnostics (FailMask/FailVec/FailValid) are built when GATE2_TESTER_DIAG_EN is defined.
module gate2_tester #(
  parameter int CHANNELS      = 4,
  parameter int GATE_FN       = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic           Clk,
  input  logic           Reset,
  gate2_tester_if.slave  bus
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {HALTED, SET, DRIVE, SAMPLE, DONE_S} state_t;

  state_t              state, state_nxt;
  logic [1:0]          vec;
  logic [CW-1:0]       cnt;
  logic                rslt_q;
  logic                exp_y;
  logic [CHANNELS-1:0] mism;

  function automatic logic gate_y(input logic a, input logic b);
    case (GATE_FN)
      0:       return ~(a & b);
      1:       return ~(a | b);
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) state <= HALTED;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HALTED: if (bus.Run) state_nxt = SET;
      SET:    state_nxt = DRIVE;
      DRIVE:  if (cnt == CNT_LAST) state_nxt = SAMPLE;
      SAMPLE: state_nxt = (vec == 2'd3) ? DONE_S : DRIVE;
      DONE_S: if (bus.DISP_RSLT) state_nxt = HALTED;
      default: state_nxt = HALTED;
    endcase
  end

  always_comb begin
    bus.DrvA = '0;
    bus.DrvB = '0;
    bus.Busy = 1'b0;
    bus.Done = 1'b0;
    case (state)
      SET:    bus.Busy = 1'b1;
      DRIVE: begin
        bus.Busy = 1'b1;
        bus.DrvA = {CHANNELS{vec[1]}};
        bus.DrvB = {CHANNELS{vec[0]}};
      end
      SAMPLE: begin
        bus.Busy = 1'b1;
        bus.DrvA = {CHANNELS{vec[1]}};
        bus.DrvB = {CHANNELS{vec[0]}};
        bus.Done = (vec == 2'd3);
      end
      DONE_S: bus.Done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    exp_y = gate_y(vec[1], vec[0]);
    mism  = (state == SAMPLE) ? (bus.Sense ^ {CHANNELS{exp_y}}) : '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vec    <= '0;
      cnt    <= '0;
      rslt_q <= 1'b0;
    end else begin
      case (state)
        SET: begin
          vec    <= '0;
          cnt    <= '0;
          rslt_q <= 1'b1;
        end
        DRIVE: cnt <= cnt + CW'(1);
        SAMPLE: begin
          if (|mism) rslt_q <= 1'b0;
          // vec stays at 3 on the final SAMPLE so it never wraps
          if (vec != 2'd3) vec <= vec + 2'd1;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.RSLT = rslt_q;

`ifdef GATE2_TESTER_DIAG_EN
  logic [CHANNELS-1:0] fail_mask_q;
  logic [1:0]          fail_vec_q;
  logic                fail_valid_q;

  always_ff @(posedge Clk) begin
    if (Reset || state == SET) begin
      fail_mask_q  <= '0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
    end else if (|mism) begin
      fail_mask_q <= fail_mask_q | mism;
      if (!fail_valid_q) begin
        fail_vec_q   <= vec;
        fail_valid_q <= 1'b1;
      end
    end
  end

  assign bus.FailMask  = fail_mask_q;
  assign bus.FailVec   = fail_vec_q;
  assign bus.FailValid = fail_valid_q;
`else
  assign bus.FailMask  = '0;
  assign bus.FailVec   = '0;
  assign bus.FailValid = 1'b0;
`endif

endmodule
